// File: rtl/saw_square_osc.sv
// Sawtooth/square audio oscillator: a free-running phase counter of L_act cycles drives both
// registered outputs; the saw step comes from a sequential divider and is adopted only at a wrap.
module saw_square_osc #(
    parameter int AMPLITUDE = 2**20,
    parameter int WIDTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wave_length,
    output logic [WIDTH-1:0] square_value,
    output logic [WIDTH-1:0] saw_value
);

    localparam int               BW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] AMP      = WIDTH'(AMPLITUDE);
    localparam logic [WIDTH-1:0] NEG_AMP  = WIDTH'(-AMPLITUDE);
    localparam logic [WIDTH-1:0] DIVIDEND = WIDTH'(2 * AMPLITUDE);
    localparam logic [WIDTH-1:0] MIN_LEN  = WIDTH'(2);

    // Phase counter, active period/step and the accumulator aligned with cnt_q
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] l_act_q, l_act_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] square_q, square_d;
    logic [WIDTH-1:0] saw_q, saw_d;

    // Divider state
    logic [WIDTH-1:0] l_req_q, l_req_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] step_next_q, step_next_d;

    logic [WIDTH-1:0] wl_clamp;
    logic             wrap;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;

    assign wl_clamp  = (wave_length < MIN_LEN) ? MIN_LEN : wave_length;
    assign wrap      = (cnt_q == (l_act_q - WIDTH'(1)));
    // Remainder stays below the divisor, so one extra bit holds the shifted value
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, l_req_q});

    always_comb begin
        cnt_d       = cnt_q;
        l_act_d     = l_act_q;
        step_d      = step_q;
        acc_d       = acc_q;
        l_req_d     = l_req_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        bit_d       = bit_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        step_next_d = step_next_q;

        if (wrap) begin
            cnt_d = '0;
            acc_d = NEG_AMP;
            if (valid_q) begin
                l_act_d = l_req_q;
                step_d  = step_next_q;
            end
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            acc_d = acc_q + step_q;
        end

        square_d = (cnt_q < (l_act_q >> 1)) ? AMP : NEG_AMP;
        saw_d    = acc_q;

        // A new request restarts the divider even mid-division; the last request wins
        if (wl_clamp != l_req_q) begin
            l_req_d = wl_clamp;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            bit_d   = '0;
            quo_d   = DIVIDEND;
            rem_d   = '0;
        end else if (busy_q) begin
            quo_d = {quo_q[WIDTH-2:0], rem_ge};
            rem_d = rem_ge ? WIDTH'(rem_shift - {1'b0, l_req_q}) : rem_shift[WIDTH-1:0];
            if (bit_q == BW'(WIDTH - 1)) begin
                busy_d      = 1'b0;
                valid_d     = 1'b1;
                step_next_d = {quo_q[WIDTH-2:0], rem_ge};
            end else begin
                bit_d = bit_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            l_act_q     <= MIN_LEN;
            step_q      <= AMP;
            acc_q       <= NEG_AMP;
            square_q    <= '0;
            saw_q       <= '0;
            l_req_q     <= MIN_LEN;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            bit_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            step_next_q <= AMP;
        end else begin
            cnt_q       <= cnt_d;
            l_act_q     <= l_act_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            square_q    <= square_d;
            saw_q       <= saw_d;
            l_req_q     <= l_req_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            bit_q       <= bit_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            step_next_q <= step_next_d;
        end
    end

    assign square_value = square_q;
    assign saw_value    = saw_q;

endmodule

// File: tb/tb_saw_square_osc.sv
// Directed bench for saw_square_osc: cycle-exact expected waveforms around reset, period
// changes (including mid-period and mid-division), clamping of short periods and the 55 Hz pitch.
module tb_saw_square_osc;

    localparam int AMP = 2**20;

    logic        clk;
    logic        reset;
    logic [31:0] wave_length;
    logic [31:0] square_value;
    logic [31:0] saw_value;

    int tests = 0;
    int fails = 0;

    saw_square_osc #(.AMPLITUDE(AMP), .WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .wave_length  (wave_length),
        .square_value (square_value),
        .saw_value    (saw_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Outputs are held at zero while reset is asserted
    task automatic run_reset(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s sq[%0d]", tag, i), square_value, 32'd0);
            check($sformatf("%s saw[%0d]", tag, i), saw_value, 32'd0);
        end
        $display("[TB] step %s: %0d reset cycles checked", tag, n);
    endtask

    // n cycles of a period-len waveform starting at phase ph0 with the given saw step
    task automatic run(input int n, input int len, input int ph0, input int step, input string tag);
        for (int i = 0; i < n; i++) begin
            int p;
            int exp_sq;
            int exp_saw;
            p       = (ph0 + i) % len;
            exp_sq  = (p < len / 2) ? AMP : -AMP;
            exp_saw = -AMP + p * step;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s sq[%0d]", tag, i), square_value, exp_sq);
            check($sformatf("%s saw[%0d]", tag, i), saw_value, exp_saw);
        end
        $display("[TB] step %s: %0d cycles L=%0d phase0=%0d step=%0d", tag, n, len, ph0, step);
    endtask

    initial begin
        reset       = 1'b1;
        wave_length = 32'd8;
        run_reset(3, "reset");
        reset = 1'b0;

        // Divider starts on the first free edge; L=2 runs until the wrap after 32 iterations
        run(34, 2, 0, AMP, "boot_L2");
        run(16, 8, 0, 262144, "L8");

        // 8 -> 16 requested mid-period: old periods continue until the post-division wrap
        run(3, 8, 0, 262144, "L8_pre");
        wave_length = 32'd16;
        run(37, 8, 3, 262144, "L8_hold");
        run(32, 16, 0, 131072, "L16");

        // Period 0 clamps to 2
        wave_length = 32'd0;
        run(48, 16, 0, 131072, "L16_hold");
        run(6, 2, 0, AMP, "L0_as_2");

        // Period 1 equals the clamped 2 already in effect: nothing changes
        wave_length = 32'd1;
        run(40, 2, 0, AMP, "L1_as_2");

        // 55 Hz at 24 MHz: step floor(2097152/436363)=4, half period 218181
        wave_length = 32'd436363;
        run(34, 2, 0, AMP, "L2_hold");
        run(20, 436363, 0, 4, "L436363");

        // Reset mid-division: the pending result for 8 must be discarded
        wave_length = 32'd8;
        run(10, 436363, 20, 4, "L436363_more");
        reset       = 1'b1;
        wave_length = 32'd2;
        run_reset(2, "reset_mid");
        reset = 1'b0;
        run(40, 2, 0, AMP, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
